// File: rtl/cpu_core_pkg.sv
// Shared core definitions: M-extension opcode fields and the mul/div unit FSM states.
package cpu_core_pkg;

    localparam logic [6:0] F7_MULDIV = 7'b000_0001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/cpu_muldiv_signfix.sv
// Operand sign handling for mul/div: converts operands to magnitudes and reports
// whether the product/quotient and the remainder must be negated afterwards.
module cpu_muldiv_signfix
    import cpu_core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg_res_c,
    output logic            neg_rem_c
);

    logic signed_a;
    logic signed_b;
    logic neg_a;
    logic neg_b;

    // Divides use funct3[0] as the unsigned flag; multiplies decode per opcode.
    always_comb begin
        signed_a  = 1'b0;
        signed_b  = 1'b0;
        if (funct3[2]) begin
            signed_a = ~funct3[0];
            signed_b = ~funct3[0];
        end else begin
            signed_a = (funct3 != F3_MULHU);
            signed_b = ~funct3[1];
        end
        neg_a     = signed_a & rs1[XLEN-1];
        neg_b     = signed_b & rs2[XLEN-1];
        mag_a     = neg_a ? -rs1 : rs1;
        mag_b     = neg_b ? -rs2 : rs2;
        neg_res_c = neg_a ^ neg_b;
        neg_rem_c = neg_a;
    end

endmodule

// File: rtl/cpu_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit, one result bit per cycle.
// Optional MULDIV_FLUSH_EN adds a flush input that abandons the current operation.
module cpu_muldiv_unit
    import cpu_core_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
`ifdef MULDIV_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN:0]    hi_q, hi_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] otag_q, otag_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [XLEN-1:0]  mag_a, mag_b;
    logic             neg_res_c, neg_rem_c;

    cpu_muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .funct3    (in_funct3),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .neg_res_c (neg_res_c),
        .neg_rem_c (neg_rem_c)
    );

    logic [XLEN:0]     mul_sum, rem_sh, diff, hi_nx;
    logic [XLEN-1:0]   a_nx, quot, remv, calc_res, special_res;
    logic [2*XLEN-1:0] prod, prod_s;
    logic              div_zero, div_ovf;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        funct3_d    = funct3_q;
        tag_d       = tag_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        res_d       = res_q;
        otag_d      = otag_q;

        // One iteration: shift-add for multiply, restoring step for divide.
        mul_sum = hi_q + (a_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        rem_sh  = {hi_q[XLEN-1:0], a_q[XLEN-1]};
        diff    = rem_sh - {1'b0, b_q};
        if (funct3_q[2]) begin
            hi_nx = diff[XLEN] ? rem_sh : diff;
            a_nx  = {a_q[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_nx = {1'b0, mul_sum[XLEN:1]};
            a_nx  = {mul_sum[0], a_q[XLEN-1:1]};
        end

        // Sign correction applied on the final iteration.
        prod   = {hi_nx[XLEN-1:0], a_nx};
        prod_s = neg_res_q ? -prod : prod;
        quot   = neg_res_q ? -a_nx : a_nx;
        remv   = neg_rem_q ? -hi_nx[XLEN-1:0] : hi_nx[XLEN-1:0];
        if (funct3_q[2]) begin
            calc_res = funct3_q[1] ? remv : quot;
        end else begin
            calc_res = (funct3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end

        div_zero    = in_funct3[2] && (in_rs2 == '0);
        div_ovf     = in_funct3[2] && !in_funct3[0] &&
                      (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
        if (div_zero) begin
            special_res = in_funct3[1] ? in_rs1 : '1;
        end else begin
            special_res = in_funct3[1] ? '0 : in_rs1;
        end

        case (state_q)
            MD_IDLE: begin
                if (in_valid) begin
                    funct3_d  = in_funct3;
                    tag_d     = in_tag;
                    neg_res_d = neg_res_c;
                    neg_rem_d = neg_rem_c;
                    if (div_zero || div_ovf) begin
                        res_d   = special_res;
                        otag_d  = in_tag;
                        state_d = MD_DONE;
                    end else begin
                        a_d     = mag_a;
                        b_d     = mag_b;
                        hi_d    = '0;
                        cnt_d   = CNT_W'(XLEN - 1);
                        state_d = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                hi_d  = hi_nx;
                a_d   = a_nx;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    res_d   = calc_res;
                    otag_d  = tag_q;
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                if (out_ready) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase

`ifdef MULDIV_FLUSH_EN
        if (flush) begin
            state_d = MD_IDLE;
        end
`endif

        in_ready_d  = (state_d == MD_IDLE);
        out_valid_d = (state_d == MD_DONE);
        busy_d      = (state_d != MD_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            funct3_q    <= '0;
            tag_q       <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            res_q       <= '0;
            otag_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            funct3_q    <= funct3_d;
            tag_q       <= tag_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            res_q       <= res_d;
            otag_q      <= otag_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign out_result = res_q;
    assign out_tag    = otag_q;

endmodule

// File: tb/tb_cpu_muldiv_unit.sv
// Directed bench for cpu_muldiv_unit (XLEN=32) with hand-computed expectations.
module tb_cpu_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;
`ifdef MULDIV_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    cpu_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
`ifdef MULDIV_FLUSH_EN
        ,
        .flush      (flush)
`endif
    );

    always #5 clk = ~clk;

    // Issue one op with out_ready high; returns result, tag and the cycle out_valid appeared.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, output logic [31:0] res,
                          output logic [4:0] rtag, output int cyc);
        @(negedge clk);
        in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_tag = t;
        in_valid  = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        res  = out_result;
        rtag = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_result !== 32'h0 || out_tag !== 5'h0) begin
            miscompares++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b res=%h tag=%h, want 1 0 0 0 0",
                     in_ready, out_valid, busy, out_result, out_tag);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic [4:0] t; int c;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'h0A, r, t, c);
        vectors++;
        if (r !== 32'hFFFF_FFEB) begin
            miscompares++; $display("FAIL mul_result: got %h want ffffffeb", r);
        end
        vectors++;
        if (t !== 5'h0A) begin
            miscompares++; $display("FAIL mul_tag: got %h want 0a", t);
        end
        vectors++;
        if (c !== 33) begin
            miscompares++; $display("FAIL mul_latency: got cycle %0d want 33", c);
        end
    endtask

    task automatic test_mulh();
        logic [31:0] r; logic [4:0] t; int c;
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'h01, r, t, c);
        vectors++;
        if (r !== 32'h4000_0000) begin
            miscompares++; $display("FAIL mulh: got %h want 40000000", r);
        end
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, r, t, c);
        vectors++;
        if (r !== 32'hFFFF_FFFE) begin
            miscompares++; $display("FAIL mulhu: got %h want fffffffe", r);
        end
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'h03, r, t, c);
        vectors++;
        if (r !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL mulhsu: got %h want ffffffff", r);
        end
    endtask

    task automatic test_div();
        logic [31:0] r; logic [4:0] t; int c;
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'h04, r, t, c);
        vectors++;
        if (r !== 32'hFFFF_FFFD) begin
            miscompares++; $display("FAIL div_neg: got %h want fffffffd", r);
        end
        vectors++;
        if (c !== 33) begin
            miscompares++; $display("FAIL div_latency: got cycle %0d want 33", c);
        end
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'h05, r, t, c);
        vectors++;
        if (r !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL rem_neg: got %h want ffffffff", r);
        end
        run_op(3'b101, 32'd100, 32'd7, 5'h06, r, t, c);
        vectors++;
        if (r !== 32'd14) begin
            miscompares++; $display("FAIL divu: got %0d want 14", r);
        end
        run_op(3'b111, 32'd100, 32'd7, 5'h07, r, t, c);
        vectors++;
        if (r !== 32'd2) begin
            miscompares++; $display("FAIL remu: got %0d want 2", r);
        end
    endtask

    task automatic test_special();
        logic [31:0] r; logic [4:0] t; int c;
        run_op(3'b100, 32'd5, 32'd0, 5'h11, r, t, c);
        vectors++;
        if (r !== 32'hFFFF_FFFF || c !== 1 || t !== 5'h11) begin
            miscompares++; $display("FAIL div_by_zero: got %h cyc %0d tag %h want ffffffff 1 11", r, c, t);
        end
        run_op(3'b110, 32'd5, 32'd0, 5'h12, r, t, c);
        vectors++;
        if (r !== 32'd5 || c !== 1) begin
            miscompares++; $display("FAIL rem_by_zero: got %h cyc %0d want 00000005 1", r, c);
        end
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'h13, r, t, c);
        vectors++;
        if (r !== 32'h8000_0000 || c !== 1) begin
            miscompares++; $display("FAIL div_overflow: got %h cyc %0d want 80000000 1", r, c);
        end
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'h14, r, t, c);
        vectors++;
        if (r !== 32'h0 || c !== 1) begin
            miscompares++; $display("FAIL rem_overflow: got %h cyc %0d want 00000000 1", r, c);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        in_funct3 = 3'b101; in_rs1 = 32'd100; in_rs2 = 32'd7; in_tag = 5'h1C;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_result !== 32'd14 || out_tag !== 5'h1C || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: vld=%b res=%0d tag=%h rdy=%b want 1 14 1c 0",
                         i, out_valid, out_result, out_tag, in_ready);
            end
            @(posedge clk); #1;
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_release: vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] r; logic [4:0] t; int c; int seen;
        @(negedge clk);
        in_funct3 = 3'b101; in_rs1 = 32'd100; in_rs2 = 32'd7; in_tag = 5'h09;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midop: vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++; $display("FAIL reset_stale: out_valid seen %0d cycles want 0", seen);
        end
        run_op(3'b111, 32'd100, 32'd7, 5'h0E, r, t, c);
        vectors++;
        if (r !== 32'd2 || t !== 5'h0E) begin
            miscompares++; $display("FAIL reset_recover: got %0d tag %h want 2 0e", r, t);
        end
    endtask

`ifdef MULDIV_FLUSH_EN
    task automatic test_flush();
        int seen;
        @(negedge clk);
        in_funct3 = 3'b101; in_rs1 = 32'd100; in_rs2 = 32'd7; in_tag = 5'h15;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_calc: vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++; $display("FAIL flush_stale: out_valid seen %0d cycles want 0", seen);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_backpressure();
        test_reset_midop();
`ifdef MULDIV_FLUSH_EN
        test_flush();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
